muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the MUL/DIV/REM class of ALU operations. It replaces the single-cycle combinational multiply, divide and remainder with an iterative shift-add multiplier and a restoring divider.
- Sits beside the ALU in the execute stage. It accepts one operation per start handshake, stalls the pipeline while iterating, and returns the result with a one-cycle done pulse.
- All operations are unsigned, and MUL returns the low WIDTH bits.

---
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_sequencer.sv | 81 ++++++++
 tb/tb_muldiv_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_sequencer
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;
   modport master (output start, op, operand_a, operand_b, flush,
                   input  busy, stall, done, result, div_by_zero);
   modport slave  (input  start, op, operand_a, operand_b, flush,
                   output busy, stall, done, result, div_by_zero);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiplier and restoring divider for MUL/DIV/REM
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_REM = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
   state_t           state, state_nx;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] result_q;
   logic             dbz_q;
   logic             accept, fast, last, q_bit;
   logic [WIDTH-1:0] rem_sh, acc_nx, mcand_nx, mplier_nx, fast_res;
   assign accept = state == IDLE && bus.start && !bus.flush;
   assign fast   = bus.op == OP_RSV || (bus.op != OP_MUL && bus.operand_b == '0);
   assign last   = cnt == CNT_W'(WIDTH - 1);
   // One iteration step; mcand doubles as dividend and collects quotient bits at its LSB
   always_comb begin
      rem_sh    = {acc[WIDTH-2:0], mcand[WIDTH-1]};
      q_bit     = rem_sh >= mplier;
      acc_nx    = op_q == OP_MUL ? acc + (mplier[0] ? mcand : '0) : (q_bit ? rem_sh - mplier : rem_sh);
      mcand_nx  = op_q == OP_MUL ? mcand << 1 : {mcand[WIDTH-2:0], q_bit};
      mplier_nx = op_q == OP_MUL ? mplier >> 1 : mplier;
      fast_res  = bus.op == OP_DIV ? '1 : bus.op == OP_REM ? bus.operand_a : '0;
   end
   // State register
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
   // Next state: flush wins over the final iteration
   always_comb begin
      state_nx = state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE) :
                 state == CALC ? (bus.flush ? IDLE : (last ? DONE : CALC)) : IDLE;
   end
   // Status outputs; a flush in DONE swallows the pulse
   always_comb begin
      bus.busy        = state == CALC;
      bus.stall       = accept || state == CALC;
      bus.done        = state == DONE && !bus.flush;
      bus.result      = result_q;
      bus.div_by_zero = dbz_q;
   end
   // Operand latch, iteration datapath and result register (written on entry to DONE)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else if (accept) begin
         op_q   <= bus.op;
         mcand  <= bus.operand_a;
         mplier <= bus.operand_b;
         acc    <= '0;
         cnt    <= '0;
         if (fast) begin
            result_q <= fast_res;
            dbz_q    <= bus.op != OP_RSV;
         end
      end else if (state == CALC && !bus.flush) begin
         acc    <= acc_nx;
         mcand  <= mcand_nx;
         mplier <= mplier_nx;
         cnt    <= cnt + 1'b1;
         if (last) begin
            result_q <= op_q == OP_DIV ? mcand_nx : acc_nx;
            dbz_q    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks against an arithmetic reference model
module tb_muldiv_sequencer;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   errs = 0;
   logic [W-1:0] held_r = '0;
   logic         held_z = 1'b0;
   muldiv_if #(.WIDTH(W)) bus ();
   muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z);
      z = 1'b0;
      case (o)
         2'd0: r = a * b;
         2'd1: if (b == 0) begin r = '1; z = 1'b1; end else r = a / b;
         2'd2: if (b == 0) begin r = a;  z = 1'b1; end else r = a % b;
         default: r = '0;
      endcase
   endfunction
   // cycle 0 presents the request; each later cycle checks handshake outputs
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int flush_at);
      logic [W-1:0] er;
      logic         ez;
      bit           fast, aborted;
      int           lat;
      model(o, a, b, er, ez);
      fast = o == 2'd3 || (o != 2'd0 && b == 0);
      lat  = fast ? 1 : W + 1;
      for (int c = 0; c <= lat + 1; c++) begin
         @(negedge clk);
         aborted = flush_at >= 0 && c > flush_at;
         bus.flush = c == flush_at;
         if (c == 0) begin
            bus.start = 1'b1;
            bus.op = o;
            bus.operand_a = a;
            bus.operand_b = b;
         end else begin
            bus.start = c == 5 && c < lat && (flush_at < 0 || c < flush_at);
            bus.op = 2'($urandom_range(0, 3));
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
         end
         #1;
         check($sformatf("stall op%0d c%0d", o, c), bus.stall, !aborted && c < lat);
         check($sformatf("busy op%0d c%0d", o, c), bus.busy, !aborted && !fast && c >= 1 && c < lat);
         check($sformatf("done op%0d c%0d", o, c), bus.done, !aborted && c == lat && flush_at != lat);
         if (c == lat && !aborted) begin
            held_r = er;
            held_z = ez;
         end
         check($sformatf("result op%0d a=%0h b=%0h c%0d", o, a, b, c), bus.result, c >= lat || aborted ? held_r : bus.result);
         if (c >= lat || aborted) check($sformatf("dbz op%0d c%0d", o, c), bus.div_by_zero, held_z);
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
   endtask
   initial begin
      logic [W-1:0] ra, rb;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (3) @(negedge clk);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst result", bus.result, 0);
      check("rst dbz", bus.div_by_zero, 0);
      rst_n = 1'b1;
      do_op(2'd0, 7, 6, -1);
      do_op(2'd0, 32'hFFFF_FFFF, 2, -1);
      do_op(2'd0, 32'h1_0000, 32'h1_0000, -1);
      do_op(2'd1, 100, 7, -1);
      do_op(2'd2, 100, 7, -1);
      do_op(2'd1, 32'h8000_0000, 1, -1);
      do_op(2'd1, 5, 0, -1);
      do_op(2'd2, 5, 0, -1);
      do_op(2'd3, 11, 3, -1);
      do_op(2'd1, 1000, 3, 10);
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      do_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, -1);
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 0;
            1: rb = W'($urandom_range(1, 20));
            2: rb = W'($urandom) >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         do_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 32)) : -1);
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'd0;
      bus.operand_a = 32'h1234;
      bus.operand_b = 32'h5678;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      held_r = '0;
      held_z = 1'b0;
      check("midrst busy", bus.busy, 0);
      check("midrst stall", bus.stall, 0);
      check("midrst done", bus.done, 0);
      check("midrst result", bus.result, 0);
      check("midrst dbz", bus.div_by_zero, 0);
      rst_n = 1'b1;
      do_op(2'd2, 9, 4, -1);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
